// File: rtl/result_writer.sv
// result_writer: captures NUM_ROWS dot-product results on `capture` and drains them one word per
// accepted transfer through a waitrequest-style write master to BASE_ADDR + 4*row.
// Optional feature macro: RESULT_WRITER_CHECKSUM_EN appends one write carrying the 32-bit
// wrapping sum of the captured rows at BASE_ADDR + 4*NUM_ROWS.
module result_writer #(
  parameter int unsigned                NUM_ROWS   = 8,
  parameter int unsigned                DATA_WIDTH = 24,
  parameter int unsigned                ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]      BASE_ADDR  = '0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 capture,
  input  logic [NUM_ROWS-1:0][DATA_WIDTH-1:0]  C_in,
  input  logic                                 clr_overrun,
  output logic [ADDR_WIDTH-1:0]                mem_address,
  output logic [31:0]                          mem_writedata,
  output logic                                 mem_write,
  input  logic                                 mem_waitrequest,
  output logic                                 busy,
  output logic                                 wb_done,
  output logic                                 overrun
);

  localparam int unsigned RowW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [RowW-1:0] LastRow = RowW'(NUM_ROWS - 1);

`ifdef RESULT_WRITER_CHECKSUM_EN
  typedef enum logic [1:0] {StIdle, StWrite, StSum, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;
`endif

  state_e                               state_q, state_d;
  logic [RowW-1:0]                      row_q, row_d;
  logic [NUM_ROWS-1:0][DATA_WIDTH-1:0]  shadow_q, shadow_d;
  logic [ADDR_WIDTH-1:0]                addr_q, addr_d;
  logic [31:0]                          wdata_q, wdata_d;
  logic                                 write_q, write_d;
  logic                                 overrun_q, overrun_d;
  logic                                 busy_s;
  logic [RowW-1:0]                      row_inc;

  function automatic logic [ADDR_WIDTH-1:0] row_addr(input logic [RowW-1:0] r);
    return BASE_ADDR + (ADDR_WIDTH'(r) << 2);
  endfunction

`ifdef RESULT_WRITER_CHECKSUM_EN
  logic [31:0] sum_s;

  // Wrapping checksum of the zero-extended shadow rows.
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < int'(NUM_ROWS); i++) begin
      sum_s = sum_s + 32'(shadow_q[i]);
    end
  end
`endif

  assign busy_s  = (state_q == StWrite)
`ifdef RESULT_WRITER_CHECKSUM_EN
                   || (state_q == StSum)
`endif
                   ;
  assign row_inc = row_q + RowW'(1);

  // Next-state, shadow capture, and registered bus outputs.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    shadow_d  = shadow_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    overrun_d = overrun_q;

    // Set wins over clear when both land in the same cycle.
    if (clr_overrun) overrun_d = 1'b0;
    if (capture && busy_s) overrun_d = 1'b1;

    unique case (state_q)
      StIdle, StDone: begin
        write_d = 1'b0;
        state_d = StIdle;
        if (capture) begin
          shadow_d = C_in;
          row_d    = '0;
          addr_d   = BASE_ADDR;
          // Shadow is not loaded until this edge, so row 0 comes straight from C_in.
          wdata_d  = 32'(C_in[0]);
          write_d  = 1'b1;
          state_d  = StWrite;
        end
      end
      StWrite: begin
        if (!mem_waitrequest) begin
          if (row_q == LastRow) begin
`ifdef RESULT_WRITER_CHECKSUM_EN
            addr_d  = BASE_ADDR + ADDR_WIDTH'(4 * NUM_ROWS);
            wdata_d = sum_s;
            state_d = StSum;
`else
            write_d = 1'b0;
            state_d = StDone;
`endif
          end else begin
            row_d   = row_inc;
            addr_d  = row_addr(row_inc);
            wdata_d = 32'(shadow_q[row_inc]);
          end
        end
      end
`ifdef RESULT_WRITER_CHECKSUM_EN
      StSum: begin
        if (!mem_waitrequest) begin
          write_d = 1'b0;
          state_d = StDone;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset drops mem_write immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      row_q     <= '0;
      shadow_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      shadow_q  <= shadow_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      overrun_q <= overrun_d;
    end
  end

  assign mem_address   = addr_q;
  assign mem_writedata = wdata_q;
  assign mem_write     = write_q;
  assign busy          = busy_s;
  assign wb_done       = (state_q == StDone);
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_result_writer.sv
// Directed bench for result_writer: reset, plain drain, stall, overrun, back-to-back with
// full-width data, and mid-frame reset. Honours RESULT_WRITER_CHECKSUM_EN like the design.
module tb_result_writer;

  logic             clk = 1'b0;
  logic             rst;
  logic             capture;
  logic [7:0][23:0] c_in;
  logic             clr_overrun;
  logic [31:0]      mem_address;
  logic [31:0]      mem_writedata;
  logic             mem_write;
  logic             mem_waitrequest;
  logic             busy;
  logic             wb_done;
  logic             overrun;

  int unsigned      vectors = 0;
  int unsigned      miscompares = 0;
  logic [31:0]      exp_row [8];

  result_writer dut (
    .clk             (clk),
    .rst             (rst),
    .capture         (capture),
    .C_in            (c_in),
    .clr_overrun     (clr_overrun),
    .mem_address     (mem_address),
    .mem_writedata   (mem_writedata),
    .mem_write       (mem_write),
    .mem_waitrequest (mem_waitrequest),
    .busy            (busy),
    .wb_done         (wb_done),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Loads c_in and the expected row table: row i = base + i (masked to 24 bits).
  task automatic load_rows(input logic [23:0] base, input bit all_same);
    for (int i = 0; i < 8; i++) begin
      c_in[i]    = all_same ? base : base + 24'(i);
      exp_row[i] = {8'h00, c_in[i]};
    end
  endtask

  // Called on the first WRITE cycle; checks every row, then the DONE cycle.
  task automatic drain(input int stall_row, input int ovr_row);
    logic [31:0] sum = '0;
    for (int r = 0; r < 8; r++) begin
      chk("addr", mem_address, 32'(4 * r));
      chk("data", mem_writedata, exp_row[r]);
      chk("write", {31'b0, mem_write}, 32'd1);
      chk("busy", {31'b0, busy}, 32'd1);
      sum = sum + exp_row[r];
      if (r == stall_row) begin
        mem_waitrequest = 1'b1;
        repeat (3) begin
          step();
          chk("stall_addr", mem_address, 32'(4 * r));
          chk("stall_data", mem_writedata, exp_row[r]);
          chk("stall_write", {31'b0, mem_write}, 32'd1);
        end
        mem_waitrequest = 1'b0;
      end
      if (r == ovr_row) begin
        capture = 1'b1;
        for (int i = 0; i < 8; i++) c_in[i] = 24'hABC000 + 24'(i);
      end
      step();
      capture = 1'b0;
    end
`ifdef RESULT_WRITER_CHECKSUM_EN
    chk("sum_addr", mem_address, 32'h20);
    chk("sum_data", mem_writedata, sum);
    chk("sum_write", {31'b0, mem_write}, 32'd1);
    step();
`endif
    chk("done", {31'b0, wb_done}, 32'd1);
    chk("done_busy", {31'b0, busy}, 32'd0);
    chk("done_write", {31'b0, mem_write}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    capture = 1'b0;
    clr_overrun = 1'b0;
    mem_waitrequest = 1'b0;
    c_in = '0;
    step();
    step();
    chk("rst_addr", mem_address, 32'h0);
    chk("rst_data", mem_writedata, 32'h0);
    chk("rst_write", {31'b0, mem_write}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, wb_done}, 32'd0);
    chk("rst_ovr", {31'b0, overrun}, 32'd0);
    rst = 1'b0;
    step();

    // Plain drain, rows 1..8.
    load_rows(24'd1, 1'b0);
    capture = 1'b1;
    step();
    capture = 1'b0;
    c_in = '0;
    drain(-1, -1);
    step();
    chk("idle_done", {31'b0, wb_done}, 32'd0);

    // Three-cycle stall on row 2.
    load_rows(24'd1, 1'b0);
    capture = 1'b1;
    step();
    capture = 1'b0;
    drain(2, -1);
    step();

    // Overrun during row 4: written data must be the original frame.
    load_rows(24'd1, 1'b0);
    capture = 1'b1;
    step();
    capture = 1'b0;
    drain(-1, 4);
    chk("ovr_set", {31'b0, overrun}, 32'd1);
    step();
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    chk("ovr_clr", {31'b0, overrun}, 32'd0);

    // Back-to-back: capture in the DONE cycle with full-width data.
    load_rows(24'd1, 1'b0);
    capture = 1'b1;
    step();
    capture = 1'b0;
    drain(-1, -1);
    load_rows(24'hFFFFFF, 1'b1);
    capture = 1'b1;
    step();
    capture = 1'b0;
    chk("b2b_ovr", {31'b0, overrun}, 32'd0);
    drain(-1, -1);
    step();

    // Mid-frame reset while row 5 is presented.
    load_rows(24'd1, 1'b0);
    capture = 1'b1;
    step();
    capture = 1'b0;
    repeat (5) step();
    chk("mid_addr", mem_address, 32'h14);
    rst = 1'b1;
    #1;
    chk("mid_write", {31'b0, mem_write}, 32'd0);
    chk("mid_busy", {31'b0, busy}, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("mid_idle", {31'b0, mem_write}, 32'd0);
    load_rows(24'd1, 1'b0);
    capture = 1'b1;
    step();
    capture = 1'b0;
    drain(-1, -1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
